// File: rtl/spi_minion_val_rdy.sv
// rtl/spi_minion_val_rdy.sv - SPI mode-0 minion with val/rdy streams; optional err_count via SPI_MINION_ERR_CNT_EN
module spi_minion_val_rdy #(
  parameter int nbits = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg
`ifdef SPI_MINION_ERR_CNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int CW = $clog2(nbits + 2);
  localparam logic [CW-1:0] BIT_FULL = CW'(nbits);
  localparam logic [CW-1:0] BIT_SAT  = CW'(nbits + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic cs_s1_q, cs_s2_q, cs_h_q;
  logic sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic mosi_s1_q, mosi_s2_q;
  logic cs_fall_q, cs_rise_q, sclk_rise_q, sclk_fall_q;

  logic [0:0]       state_q, state_d;
  logic [nbits-1:0] tx_q, tx_d;
  logic [nbits-1:0] rx_q, rx_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             send_val_q, send_val_d;
  logic [nbits-1:0] send_msg_q, send_msg_d;
  logic             recv_fire;

  // Synchronize the pins and register one-cycle edge pulses; cs resets low so a frame in flight at reset release never starts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_s1_q     <= 1'b0;
      cs_s2_q     <= 1'b0;
      cs_h_q      <= 1'b0;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_h_q    <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
    end else begin
      cs_s1_q     <= cs;
      cs_s2_q     <= cs_s1_q;
      cs_h_q      <= cs_s2_q;
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_h_q    <= sclk_s2_q;
      mosi_s1_q   <= mosi;
      mosi_s2_q   <= mosi_s1_q;
      cs_fall_q   <= cs_h_q & ~cs_s2_q;
      cs_rise_q   <= ~cs_h_q & cs_s2_q;
      sclk_rise_q <= ~sclk_h_q & sclk_s2_q;
      sclk_fall_q <= sclk_h_q & ~sclk_s2_q;
    end
  end

  // Frame FSM, shift registers and the one-deep output register; a cs edge masks any sclk edge in the same cycle
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bitcnt_d   = bitcnt_q;
    send_val_d = send_val_q;
    send_msg_d = send_msg_q;
    recv_fire  = 1'b0;
    // A word consumed this cycle frees the register for a frame finishing in the same cycle
    if (send_val_q && send_rdy) begin
      send_val_d = 1'b0;
    end
    if (state_q == ST_IDLE) begin
      if (cs_fall_q) begin
        state_d   = ST_ACTIVE;
        recv_fire = recv_val;
        tx_d      = recv_val ? recv_msg : '0;
        rx_d      = '0;
        bitcnt_d  = '0;
      end
    end else begin
      if (cs_rise_q) begin
        state_d = ST_IDLE;
        if (bitcnt_q == BIT_FULL && !send_val_d) begin
          send_val_d = 1'b1;
          send_msg_d = rx_q;
        end
      end else begin
        if (sclk_rise_q) begin
          rx_d = {rx_q[nbits-2:0], mosi_s2_q};
          if (bitcnt_q != BIT_SAT) begin
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end
        if (sclk_fall_q) begin
          tx_d = {tx_q[nbits-2:0], 1'b0};
        end
      end
    end
  end

  // Register the frame state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      bitcnt_q   <= '0;
      send_val_q <= 1'b0;
      send_msg_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bitcnt_q   <= bitcnt_d;
      send_val_q <= send_val_d;
      send_msg_q <= send_msg_d;
    end
  end

  assign recv_rdy = recv_fire;
  assign miso     = (state_q == ST_ACTIVE) & tx_q[nbits-1];
  assign send_val = send_val_q;
  assign send_msg = send_msg_q;

`ifdef SPI_MINION_ERR_CNT_EN
  logic       drop;
  logic [7:0] err_q;

  // A frame ending with a wrong bit count, or while the held word is not being consumed, is dropped
  assign drop = (state_q == ST_ACTIVE) & cs_rise_q &
                ((bitcnt_q != BIT_FULL) | (send_val_q & ~send_rdy));

  // Saturating dropped-frame counter, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 8'd0;
    end else if (drop && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: doc/spi_minion_val_rdy.md
# spi_minion_val_rdy

SPI mode-0 minion (slave) with val/rdy streaming ports: the responder end of the team's SPI master. It oversamples `cs`, `sclk` and `mosi` on the system clock. Each full `nbits`-bit frame from `mosi` is delivered on the `send` port. The word taken from the `recv` port is shifted out on `miso` in the same frame. It sits behind chip pins in designs driven by an external SPI master.

## Interface
Parameters:
- `nbits`, 34: frame/message width in bits; legal range 2–255.

Ports:
- `clk`, input, 1: system clock; the only clock.
- `reset`, input, 1: asynchronous, active-low reset (0 = in reset).
- `cs`, input, 1: chip select, active-low; asynchronous to `clk`.
- `sclk`, input, 1: SPI clock, idle low; asynchronous to `clk`.
- `mosi`, input, 1: serial data in; asynchronous to `clk`.
- `miso`, output, 1: serial data out.
- `recv_val`, input, 1: valid for the word to transmit.
- `recv_rdy`, output, 1: ready for the word to transmit.
- `recv_msg`, input, `nbits`: word to transmit, MSB first.
- `send_val`, output, 1: valid for the received word.
- `send_rdy`, input, 1: ready for the received word.
- `send_msg`, output, `nbits`: received word, first bit at the MSB.
- `err_count`, output, 8: dropped-frame counter; present only with `SPI_MINION_ERR_CNT_EN`.

## Operation
- **Input sync:** `cs`, `sclk` and `mosi` each pass through a 2-flop synchronizer, then one edge-detect flop.
  - Synchronizer reset values: `cs` 0, `sclk` 0, `mosi` 0.
  - Because `cs` resets to 0, a frame in progress at reset release is never treated as started.
- **FSM:**
  - IDLE → ACTIVE on a detected `cs` fall.
  - ACTIVE → IDLE on a detected `cs` rise.
  - A `cs` rise while in IDLE is ignored.
- **Frame start (cs fall):**
  - If `recv_val`=1: load `tx_shreg` ← `recv_msg` and drive `recv_rdy`=1 for that one cycle (transfer fires).
  - Otherwise: load `tx_shreg` ← 0.
  - In both cases clear `rx_shreg` and `bitcnt`.
- **Idle rule:** `recv_rdy` is 0 at all other times.
- **sclk rise (ACTIVE):**
  - `rx_shreg` ← {`rx_shreg[nbits-2:0]`, `mosi_sync`}.
  - `bitcnt` increments and saturates at `nbits`+1.
- **sclk fall (ACTIVE):** `tx_shreg` ← {`tx_shreg[nbits-2:0]`, 0}.
- **miso:** equals `tx_shreg[nbits-1]` in ACTIVE and 0 in IDLE. It is always driven, never tri-stated.
- **Frame end (cs rise):**
  - If `bitcnt`==`nbits` and the output register is empty: load `send_msg` ← `rx_shreg` and set `send_val`=1.
  - If `bitcnt` != `nbits` (short or long frame): drop the frame.
  - If `send_val` is still 1 (overflow): drop the new frame; the held word is kept unchanged.
- **Send handshake:**
  - `send_val` stays high until the cycle with `send_val & send_rdy`; it clears at the next edge.
  - A new frame completing in that same cycle is accepted (the register counts as empty).
  - `send_msg` is stable while `send_val`=1.
- **Simultaneous sclk and cs edges** detected in the same cycle: the cs edge wins and the sclk edge is ignored.

## Timing
- **Reset values:** `miso`=0, `recv_rdy`=0, `send_val`=0, `send_msg`=0, `err_count`=0; FSM in IDLE.
- **Pin to detected edge:** 3 `clk` cycles.
- **Pin to action:** the action registers on the following edge, so 4 cycles from pin change to effect.
- **`miso` settle:** `miso` is valid ≤4 `clk` cycles after the `cs` fall or the `sclk` fall.
- **`send_val` rise:** 4 `clk` cycles after the `cs` pin rises.
- **Master constraints:**
  - `sclk` high and low phases ≥6 `clk` cycles each.
  - `cs` fall to first `sclk` rise ≥6 cycles.
  - Last `sclk` fall to `cs` rise ≥6 cycles.
  - `cs` high time between frames ≥6 cycles.
- **Throughput:** one frame buffered. The consumer must drain `send` within one frame time to avoid overflow.

## Configuration
- Macro: `SPI_MINION_ERR_CNT_EN`.
- **Defined:** adds output `err_count[7:0]`.
  - Increments by 1 on each dropped frame (length error or overflow).
  - Saturates at 255.
  - Cleared only by reset.
- **Undefined:** the port is absent; drops are silent. All other behaviour is identical.

## Test plan
Bench uses `nbits`=8 and the macro defined.

- **Basic frame:** `recv_msg`=0xA5 with `recv_val`=1; master sends 0x3C. Required: `recv_rdy` pulses once; `miso` bits read 1,0,1,0,0,1,0,1; `send_msg`=0x3C with `send_val`=1 until `send_rdy`.
- **No tx data:** `recv_val`=0; master sends 0xFF. Required: `miso` reads 0x00, `send_msg`=0xFF, `recv_rdy` never asserts.
- **Length errors:** 7-bit frame, then 9-bit frame. Required: `send_val` stays 0 and `err_count`=2. A following 8-bit frame of 0x81 then delivers 0x81.
- **Overflow:** `send_rdy`=0; frames 0x11 then 0x22. Required: `send_msg` stays 0x11 and `err_count`=1. Assert `send_rdy` → 0x11 accepted and nothing further is delivered.
- **Reset mid-frame:** assert reset after 4 bits, release while `cs` is still low, finish the frame. Required: no `send_val` and no `err_count` change. The next full frame of 0x5A delivers correctly.
- **Backpressure boundary:** `send_rdy` rises in the same cycle a new frame completes. Required: the old word is accepted, then the new word is presented the next cycle with no error counted.
